iomem_block_bridge: RTL

- Downstream neighbour of the core top. It consumes the core's 128-bit block bus (iomem_valid, iomem_ready, iomem_addr, iomem_wstrb, iomem_wdata, iomem_rdata).
- Each block request is serialised into single-word transactions on a 32-bit req/gnt/rvalid memory port (SRAM or peripheral fabric).
- Read block data is reassembled and returned with a one-cycle ready pulse.
- Only one block request and one word transaction are in flight at a time.

---
 rtl/iomem_block_bridge_pkg.sv | 30 +++
 rtl/iomem_block_bridge_blk_word_sel.sv | 31 +++
 rtl/iomem_block_bridge.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/iomem_block_bridge_pkg.sv
// Shared types and constants for the iomem block bridge.
// Block geometry: 128-bit blocks split into 4 x 32-bit words, 16 byte strobes.
// Optional watchdog feature: IOMEM_BRIDGE_TIMEOUT_EN (see iomem_block_bridge.sv).
package iomem_block_bridge_pkg;

   localparam int unsigned BRIDGE_XLEN     = 32;
   localparam int unsigned BRIDGE_BLK_SIZE = 128;
   localparam int unsigned BLK_WORDS       = BRIDGE_BLK_SIZE / BRIDGE_XLEN;
   localparam int unsigned BLK_IDX_W       = $clog2(BLK_WORDS);
   localparam int unsigned BLK_STRB_W      = BRIDGE_BLK_SIZE / 8;

   // Filler returned for every word abandoned by the watchdog.
   localparam logic [BRIDGE_XLEN-1:0] BRIDGE_ERR_WORD = 32'hDEADBEEF;

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StWaitRsp,
      StDone
   } bridge_state_e;

   typedef struct packed {
      logic                   req;
      logic                   we;
      logic [BRIDGE_XLEN-1:0] addr;
      logic [3:0]             be;
      logic [BRIDGE_XLEN-1:0] wdata;
   } word_req_t;

endpackage

// File: rtl/iomem_block_bridge_blk_word_sel.sv
// Word selector for the block bridge (purely combinational).
// Finds the lowest word whose strobe nibble is nonzero: either the first such word in the
// block (sel_first_i) or the first one strictly above idx_i.
//   strb_i      : 16-bit byte strobe mask (all-ones for reads)
//   idx_i       : current word index
//   sel_first_i : 1 = search from word 0, 0 = search above idx_i
//   next_idx_o  : selected word index
//   none_left_o : no qualifying word exists
module iomem_block_bridge_blk_word_sel
   import iomem_block_bridge_pkg::*;
(
   input  logic [BLK_STRB_W-1:0] strb_i,
   input  logic [BLK_IDX_W-1:0]  idx_i,
   input  logic                  sel_first_i,
   output logic [BLK_IDX_W-1:0]  next_idx_o,
   output logic                  none_left_o
);

   // Scan downwards so the lowest qualifying word wins.
   always_comb begin
      next_idx_o  = '0;
      none_left_o = 1'b1;
      for (int i = int'(BLK_WORDS) - 1; i >= 0; i--) begin
         if ((|strb_i[i*4 +: 4]) && (sel_first_i || (i > int'(idx_i)))) begin
            next_idx_o  = BLK_IDX_W'(i);
            none_left_o = 1'b0;
         end
      end
   end

endmodule

// File: rtl/iomem_block_bridge.sv
// Block-to-word bridge: serialises one 128-bit block request into ascending single-word
// req/gnt/rvalid transactions and reassembles read data, finishing with a one-cycle
// blk_ready_o pulse. One block and one word are in flight at a time.
// Ports:
//   clk_i, rst_ni        : clock; synchronous active-high reset (despite the name)
//   blk_valid_i/addr/wstrb/wdata : block request (wstrb == 0 means read)
//   blk_ready_o, blk_rdata_o     : completion pulse and reassembled read block
//   mem_req_o/we/addr/be/wdata   : word request, held stable until mem_gnt_i
//   mem_gnt_i, mem_rvalid_i, mem_rdata_i : word accept / response
//   err_o                : sticky watchdog error
// Optional feature: define IOMEM_BRIDGE_TIMEOUT_EN to enable an 8-bit watchdog that abandons
// a stalled block after TIMEOUT_CYC cycles in one state; otherwise err_o is tied 0.
// Internal word/block widths come from iomem_block_bridge_pkg; XLEN/BLK_SIZE must match it.
module iomem_block_bridge
   import iomem_block_bridge_pkg::*;
#(
   parameter int unsigned XLEN        = BRIDGE_XLEN,
   parameter int unsigned BLK_SIZE    = BRIDGE_BLK_SIZE,
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  blk_valid_i,
   input  logic [XLEN-1:0]       blk_addr_i,
   input  logic [BLK_STRB_W-1:0] blk_wstrb_i,
   input  logic [BLK_SIZE-1:0]   blk_wdata_i,
   output logic                  blk_ready_o,
   output logic [BLK_SIZE-1:0]   blk_rdata_o,
   output logic                  mem_req_o,
   output logic                  mem_we_o,
   output logic [XLEN-1:0]       mem_addr_o,
   output logic [3:0]            mem_be_o,
   output logic [XLEN-1:0]       mem_wdata_o,
   input  logic                  mem_gnt_i,
   input  logic                  mem_rvalid_i,
   input  logic [XLEN-1:0]       mem_rdata_i,
   output logic                  err_o
);

   bridge_state_e         state_q, state_d;
   logic [XLEN-1:0]       base_q, base_d;
   logic [BLK_STRB_W-1:0] wstrb_q, wstrb_d;
   logic [BLK_SIZE-1:0]   wdata_q, wdata_d;
   logic [BLK_SIZE-1:0]   rdata_q, rdata_d;
   logic                  we_q, we_d;
   logic [BLK_IDX_W-1:0]  idx_q, idx_d;

   word_req_t             word;
   logic                  blk_ready;
   logic                  sel_first;
   logic [BLK_STRB_W-1:0] sel_strb;
   logic [BLK_IDX_W-1:0]  sel_idx;
   logic                  sel_none;
   logic                  timeout_hit;
   logic                  abort;

   // Low address bits select bytes inside the block and carry no meaning here.
   logic unused_addr_lsb;
   assign unused_addr_lsb = ^blk_addr_i[3:0];

   // In IDLE the selector looks at the incoming strobes; afterwards at the latched ones.
   // Reads use an all-ones mask so every word is served in order.
   assign sel_first = (state_q == StIdle);

   always_comb begin
      sel_strb = '1;
      if (sel_first) begin
         if (|blk_wstrb_i) begin
            sel_strb = blk_wstrb_i;
         end
      end else if (we_q) begin
         sel_strb = wstrb_q;
      end
   end

   iomem_block_bridge_blk_word_sel u_word_sel (
      .strb_i      (sel_strb),
      .idx_i       (idx_q),
      .sel_first_i (sel_first),
      .next_idx_o  (sel_idx),
      .none_left_o (sel_none)
   );

   always_comb begin
      state_d   = state_q;
      base_d    = base_q;
      wstrb_d   = wstrb_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      we_d      = we_q;
      idx_d     = idx_q;
      word      = '0;
      blk_ready = 1'b0;
      abort     = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (blk_valid_i) begin
               base_d  = {blk_addr_i[XLEN-1:4], 4'b0000};
               wstrb_d = blk_wstrb_i;
               wdata_d = blk_wdata_i;
               we_d    = |blk_wstrb_i;
               idx_d   = sel_idx;
               state_d = StReq;
            end
         end

         StReq: begin
            word.req   = 1'b1;
            word.we    = we_q;
            word.addr  = base_q + {{(XLEN-BLK_IDX_W-2){1'b0}}, idx_q, 2'b00};
            word.be    = we_q ? wstrb_q[int'(idx_q)*4 +: 4] : 4'hF;
            word.wdata = wdata_q[int'(idx_q)*XLEN +: XLEN];
            if (mem_gnt_i) begin
               state_d = StWaitRsp;
            end else if (timeout_hit) begin
               abort = 1'b1;
            end
         end

         StWaitRsp: begin
            if (mem_rvalid_i) begin
               if (!we_q) begin
                  rdata_d[int'(idx_q)*XLEN +: XLEN] = mem_rdata_i;
               end
               if (sel_none) begin
                  state_d = StDone;
               end else begin
                  idx_d   = sel_idx;
                  state_d = StReq;
               end
            end else if (timeout_hit) begin
               abort = 1'b1;
            end
         end

         StDone: begin
            blk_ready = 1'b1;
            state_d   = StIdle;
         end

         default: state_d = StIdle;
      endcase

      // Abandoned words (current and all later ones) complete as error filler.
      if (abort) begin
         for (int i = 0; i < int'(BLK_WORDS); i++) begin
            if (i >= int'(idx_q)) begin
               rdata_d[i*XLEN +: XLEN] = BRIDGE_ERR_WORD;
            end
         end
         state_d = StDone;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_ni) begin
         state_q <= StIdle;
         base_q  <= '0;
         wstrb_q <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         we_q    <= 1'b0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         wstrb_q <= wstrb_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         we_q    <= we_d;
         idx_q   <= idx_d;
      end
   end

`ifdef IOMEM_BRIDGE_TIMEOUT_EN
   logic [7:0] cnt_q, cnt_d;
   logic       err_q, err_d;
   logic       busy;

   assign busy        = (state_q == StReq) || (state_q == StWaitRsp);
   assign timeout_hit = busy && (cnt_q == 8'(TIMEOUT_CYC));

   // Counts cycles spent in the current state; any state change restarts it.
   always_comb begin
      cnt_d = '0;
      if (busy && (state_d == state_q)) begin
         cnt_d = cnt_q + 8'd1;
      end
      err_d = err_q | abort;
   end

   always_ff @(posedge clk_i) begin
      if (rst_ni) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign err_o = err_q;
`else
   assign timeout_hit = 1'b0;
   assign err_o       = 1'b0;

   logic unused_timeout;
   assign unused_timeout = abort ^ (TIMEOUT_CYC != 0);
`endif

   assign mem_req_o   = word.req;
   assign mem_we_o    = word.we;
   assign mem_addr_o  = word.addr;
   assign mem_be_o    = word.be;
   assign mem_wdata_o = word.wdata;
   assign blk_ready_o = blk_ready;
   assign blk_rdata_o = rdata_q;

endmodule
